// File: rtl/reaction_pkg.sv
// reaction_pkg: shared definitions for the reaction-time BCD timer.
//   state_t       - controller-facing FSM states (IDLE, COUNT, HOLD)
//   DEF_TICK_DIV  - default clock cycles per millisecond tick (50 MHz clock)
//   BCD_W         - bit width of one packed BCD decade
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV = 50000;
    localparam int BCD_W        = 4;

endpackage

// File: rtl/reaction_bcd_timer_bcd_digit.sv
// bcd_digit: one BCD decade of the reaction-time counter.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-high reset, digit -> 0
//   clr       - synchronous clear, digit -> 0 (wins over inc_in)
//   inc_in    - increment request from the previous decade (or the tick)
//   digit     - registered digit value, always 0..9
//   carry_out - inc_in while digit is 9: this decade wraps, next one counts
module bcd_digit
    import reaction_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_nine;

    assign at_nine = (digit_q == BCD_W'(9));

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc_in) begin
            digit_d = at_nine ? '0 : digit_q + BCD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc_in && at_nine;

endmodule

// File: rtl/reaction_bcd_timer.sv
// reaction_bcd_timer: millisecond reaction timer with packed BCD output.
// Counting starts when the controller raises go (stop low), freezes on stop,
// and the frozen result is held for the display. Optionally tracks the best
// (lowest, non-overflowed) result since reset.
// Configuration macro: REACTION_BEST_EN - when defined, best / best_valid /
// new_best and the compare logic are built; otherwise they are tied to 0.
// Ports:
//   clock, reset     - clock, asynchronous active-high reset
//   go, stop         - run / stop levels from the game controller
//   count            - packed BCD elapsed time, digit 0 in the LSBs
//   running, done    - registered decodes of COUNT and HOLD
//   overflow         - count saturated at all-nines during this run
//   best, best_valid - lowest valid result since reset and its valid flag
//   new_best         - one-cycle pulse when best is loaded
//   dbg_state        - current FSM state for observation
// Handshake: go/stop are levels on the same clock. IDLE->COUNT needs go=1,
// stop=0; stop=1 in COUNT freezes into HOLD; go=0,stop=0 returns to IDLE.
module reaction_bcd_timer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DIGITS   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      stop,
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic                      running,
    output logic                      done,
    output logic                      overflow,
    output logic [BCD_W*DIGITS-1:0]   best,
    output logic                      best_valid,
    output logic                      new_best,
    output state_t                    dbg_state
);

    localparam int CW = BCD_W * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        state_q;
    logic          running_q;
    logic          done_q;
    logic          overflow_q;
    logic [PW-1:0] prescaler_q;

    logic              tick;
    logic              start;
    logic              stay_count;
    logic              sat;
    logic              top_carry;
    logic [DIGITS:0]   inc_c;
    logic [DIGITS-1:0] nine;

    assign tick       = (prescaler_q == PW'(TICK_DIV - 1));
    assign start      = (state_q == IDLE) && go && !stop;
    // Increments only while the run continues: stop has priority over a
    // coincident tick, and an aborted run keeps its count untouched.
    assign stay_count = (state_q == COUNT) && go && !stop;
    assign sat        = &nine;
    assign inc_c[0]   = stay_count && tick && !sat;
    assign top_carry  = inc_c[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign nine[i] = (count[i*BCD_W +: BCD_W] == BCD_W'(9));

        bcd_digit u_digit (
            .clock     (clock),
            .reset     (reset),
            .clr       (start),
            .inc_in    (inc_c[i]),
            .digit     (count[i*BCD_W +: BCD_W]),
            .carry_out (inc_c[i+1])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            prescaler_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go && !stop) begin
                        state_q     <= COUNT;
                        running_q   <= 1'b1;
                        overflow_q  <= 1'b0;
                        prescaler_q <= '0;
                    end
                end
                COUNT: begin
                    if (stop) begin
                        state_q   <= HOLD;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (!go) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end else begin
                        prescaler_q <= tick ? '0 : prescaler_q + PW'(1);
                        // Saturation gates the chain, so the top carry cannot
                        // fire; it is folded in so a wrap would still flag.
                        if ((tick && sat) || top_carry) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!go && !stop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign running   = running_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

`ifdef REACTION_BEST_EN
    logic [CW-1:0] best_q;
    logic          best_valid_q;
    logic          new_best_q;
    logic          cmp_pending_q;

    // The compare runs the cycle after HOLD entry, on the frozen count.
    // A plain unsigned compare is a correct BCD compare since every digit
    // stays within 0..9.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            best_q        <= '0;
            best_valid_q  <= 1'b0;
            new_best_q    <= 1'b0;
            cmp_pending_q <= 1'b0;
        end else begin
            cmp_pending_q <= (state_q == COUNT) && stop;
            new_best_q    <= 1'b0;
            if (cmp_pending_q && !overflow_q &&
                (!best_valid_q || (count < best_q))) begin
                best_q       <= count;
                best_valid_q <= 1'b1;
                new_best_q   <= 1'b1;
            end
        end
    end

    assign best       = best_q;
    assign best_valid = best_valid_q;
    assign new_best   = new_best_q;
`else
    assign best       = '0;
    assign best_valid = 1'b0;
    assign new_best   = 1'b0;
`endif

endmodule
